// File: rtl/al_gpio_bank.sv
// al_gpio_bank: N-channel GPIO bank with synchronised, debounced inputs,
// edge-detect interrupts and a single-cycle req/ack register port.
module al_gpio_bank #(
    parameter int unsigned N         = 16,
    parameter int unsigned DB_CYCLES = 8,
    parameter int unsigned DB_W      = 8
) (
    input  logic         ppm_clk,
    input  logic         rst_n,
    input  logic [N-1:0] gpio_in,
    output logic [N-1:0] gpio_out,
    output logic [N-1:0] gpio_oe_n,
    input  logic         bus_req,
    input  logic         bus_we,
    input  logic [2:0]   bus_addr,
    input  logic [N-1:0] bus_wdata,
    output logic [N-1:0] bus_rdata,
    output logic         bus_ack,
    output logic         irq
);

    localparam logic [2:0] A_DATA_OUT   = 3'd0;
    localparam logic [2:0] A_DIR        = 3'd1;
    localparam logic [2:0] A_DATA_IN    = 3'd2;
    localparam logic [2:0] A_IRQ_EN     = 3'd3;
    localparam logic [2:0] A_IRQ_RISE   = 3'd4;
    localparam logic [2:0] A_IRQ_FALL   = 3'd5;
    localparam logic [2:0] A_IRQ_STATUS = 3'd6;

    // Terminal count of the debounce counter (unused when the filter is bypassed)
    localparam int unsigned DB_LAST = (DB_CYCLES == 0) ? 0 : DB_CYCLES - 1;

    logic [N-1:0]    data_out_q;
    logic [N-1:0]    oe_n_q;
    logic [N-1:0]    irq_en_q;
    logic [N-1:0]    irq_rise_q;
    logic [N-1:0]    irq_fall_q;
    logic [N-1:0]    status_q;
    logic [N-1:0]    sync1_q;
    logic [N-1:0]    sync2_q;
    logic [N-1:0]    stable_q;
    logic [DB_W-1:0] cnt_q [N];
    logic [N-1:0]    rdata_q;
    logic            ack_q;
    logic            irq_q;

    logic            wr_c;
    logic            rd_c;
    logic [N-1:0]    rd_mux_c;
    logic [N-1:0]    stable_d;
    logic [DB_W-1:0] cnt_d [N];
    logic [N-1:0]    set_c;
    logic [N-1:0]    clr_c;
    logic [N-1:0]    status_d;

    assign gpio_out  = data_out_q;
    assign gpio_oe_n = oe_n_q;
    assign bus_rdata = rdata_q;
    assign bus_ack   = ack_q;
    assign irq       = irq_q;

    // Access decode
    always_comb begin
        wr_c = bus_req & bus_we;
        rd_c = bus_req & ~bus_we;
    end

    // Read data selection
    always_comb begin
        rd_mux_c = '0;
        case (bus_addr)
            A_DATA_OUT:   rd_mux_c = data_out_q;
            A_DIR:        rd_mux_c = ~oe_n_q;
            A_DATA_IN:    rd_mux_c = stable_q;
            A_IRQ_EN:     rd_mux_c = irq_en_q;
            A_IRQ_RISE:   rd_mux_c = irq_rise_q;
            A_IRQ_FALL:   rd_mux_c = irq_fall_q;
            A_IRQ_STATUS: rd_mux_c = status_q;
            default:      rd_mux_c = '0;
        endcase
    end

    // Debounce filter next state per channel
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(N); i++) begin
            cnt_d[i] = '0;
            if (DB_CYCLES == 0) begin
                stable_d[i] = sync2_q[i];
            end else if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == DB_W'(DB_LAST)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Edge events and W1C; a set on the same edge as a clear wins
    always_comb begin
        set_c    = (stable_d & ~stable_q & irq_rise_q) | (~stable_d & stable_q & irq_fall_q);
        clr_c    = (wr_c && bus_addr == A_IRQ_STATUS) ? bus_wdata : '0;
        status_d = (status_q & ~clr_c) | set_c;
    end

    // Software-writable configuration registers
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            oe_n_q     <= '1;
            irq_en_q   <= '0;
            irq_rise_q <= '0;
            irq_fall_q <= '0;
        end else if (wr_c) begin
            case (bus_addr)
                A_DATA_OUT: data_out_q <= bus_wdata;
                A_DIR:      oe_n_q     <= ~bus_wdata;
                A_IRQ_EN:   irq_en_q   <= bus_wdata;
                A_IRQ_RISE: irq_rise_q <= bus_wdata;
                A_IRQ_FALL: irq_fall_q <= bus_wdata;
                default:    ;
            endcase
        end
    end

    // Input synchroniser, debounce state and interrupt status
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            status_q <= '0;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            status_q <= status_d;
            for (int i = 0; i < int'(N); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Bus response and masked interrupt output
    always_ff @(posedge ppm_clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            ack_q   <= bus_req;
            rdata_q <= rd_c ? rd_mux_c : '0;
            irq_q   <= |(status_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_al_gpio_bank.sv
// Directed testbench for al_gpio_bank (N=16, DB_CYCLES=8).
module tb_al_gpio_bank;

    logic        ppm_clk;
    logic        rst_n;
    logic [15:0] gpio_in;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oe_n;
    logic        bus_req;
    logic        bus_we;
    logic [2:0]  bus_addr;
    logic [15:0] bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_ack;
    logic        irq;

    int vecs;
    int errs;

    al_gpio_bank #(.N(16), .DB_CYCLES(8), .DB_W(8)) dut (
        .ppm_clk   (ppm_clk),
        .rst_n     (rst_n),
        .gpio_in   (gpio_in),
        .gpio_out  (gpio_out),
        .gpio_oe_n (gpio_oe_n),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .irq       (irq)
    );

    initial ppm_clk = 1'b0;
    always #5 ppm_clk = ~ppm_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: drive at negedge, sampled at next posedge T, response checked at following negedge.
    task automatic acc(input logic we, input logic [2:0] a, input logic [15:0] d, output logic [15:0] rd);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = a;
        bus_wdata = d;
        @(posedge ppm_clk);
        @(negedge ppm_clk);
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = '0;
        chk("ack", 32'(bus_ack), 32'd1);
        rd = bus_rdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] unused;
        acc(1'b1, a, d, unused);
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [15:0] exp);
        logic [15:0] rd;
        acc(1'b0, a, 16'h0, rd);
        chk(tag, 32'(rd), 32'(exp));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ppm_clk);
    endtask

    initial begin
        vecs      = 0;
        errs      = 0;
        rst_n     = 1'b0;
        gpio_in   = '0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        cyc(3);
        chk("rst_oe_n",  32'(gpio_oe_n), 32'h0000_FFFF);
        chk("rst_out",   32'(gpio_out),  32'h0);
        chk("rst_ack",   32'(bus_ack),   32'h0);
        chk("rst_irq",   32'(irq),       32'h0);
        chk("rst_rdata", 32'(bus_rdata), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // All registers read 0 after reset; ack is a single pulse
        for (int i = 0; i < 8; i++) rdchk($sformatf("rst_reg%0d", i), 3'(i), 16'h0);
        cyc(1);
        chk("ack_pulse", 32'(bus_ack), 32'h0);

        // Direction and output data take effect on the write edge
        wr(3'd1, 16'h00F0);
        chk("oe_n_wr", 32'(gpio_oe_n), 32'h0000_FF0F);
        wr(3'd0, 16'hA5A5);
        chk("out_wr", 32'(gpio_out), 32'h0000_A5A5);
        rdchk("rd_dir", 3'd1, 16'h00F0);
        rdchk("rd_dout", 3'd0, 16'hA5A5);
        // Write to RO register and index 7 are ignored
        wr(3'd2, 16'hFFFF);
        wr(3'd7, 16'hFFFF);
        rdchk("rd_din_ro", 3'd2, 16'h0000);
        rdchk("rd_idx7", 3'd7, 16'h0000);
        chk("out_keep", 32'(gpio_out), 32'h0000_A5A5);

        // Interrupt setup: rise on ch0/ch3, enabled on ch0/ch3
        wr(3'd4, 16'h0009);
        wr(3'd3, 16'h0009);
        rdchk("rd_rise", 3'd4, 16'h0009);

        // 5-cycle glitch on ch3 is filtered out
        gpio_in[3] = 1'b1;
        cyc(5);
        gpio_in[3] = 1'b0;
        cyc(15);
        chk("glitch_irq", 32'(irq), 32'h0);
        rdchk("glitch_din", 3'd2, 16'h0000);
        rdchk("glitch_stat", 3'd6, 16'h0000);

        // Sustained level on ch3: status at E+9, irq at E+10
        gpio_in[3] = 1'b1;
        cyc(10);
        chk("db_irq_early", 32'(irq), 32'h0);
        cyc(1);
        chk("db_irq_on", 32'(irq), 32'h1);
        rdchk("db_din", 3'd2, 16'h0008);
        rdchk("db_stat", 3'd6, 16'h0008);
        wr(3'd6, 16'h0008);
        chk("w1c3_irq_hold", 32'(irq), 32'h1);
        cyc(1);
        chk("w1c3_irq_off", 32'(irq), 32'h0);
        gpio_in[3] = 1'b0;
        cyc(15);
        rdchk("fall3_nostat", 3'd6, 16'h0000);
        rdchk("fall3_din", 3'd2, 16'h0000);

        // Channel 0 rising edge, then falling edge with no fall enable
        gpio_in[0] = 1'b1;
        cyc(10);
        chk("ch0_irq_early", 32'(irq), 32'h0);
        cyc(1);
        chk("ch0_irq_on", 32'(irq), 32'h1);
        rdchk("ch0_stat", 3'd6, 16'h0001);
        gpio_in[0] = 1'b0;
        cyc(15);
        rdchk("ch0_fall_stat", 3'd6, 16'h0001);
        wr(3'd6, 16'h0001);
        cyc(1);
        chk("ch0_w1c_irq", 32'(irq), 32'h0);
        rdchk("ch0_w1c_stat", 3'd6, 16'h0000);

        // Set wins over a simultaneous W1C: fall event on ch0 collides with clear
        wr(3'd5, 16'h0001);
        gpio_in[0] = 1'b1;
        cyc(11);
        chk("coll_pre_irq", 32'(irq), 32'h1);
        gpio_in[0] = 1'b0;
        cyc(9);
        wr(3'd6, 16'h0001);
        chk("coll_irq0", 32'(irq), 32'h1);
        cyc(1);
        chk("coll_irq1", 32'(irq), 32'h1);
        rdchk("coll_stat", 3'd6, 16'h0001);

        // Asynchronous reset while irq=1 and a read is in flight
        bus_req  = 1'b1;
        bus_we   = 1'b0;
        bus_addr = 3'd6;
        @(posedge ppm_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ack",   32'(bus_ack),   32'h0);
        chk("arst_rdata", 32'(bus_rdata), 32'h0);
        chk("arst_irq",   32'(irq),       32'h0);
        chk("arst_out",   32'(gpio_out),  32'h0);
        chk("arst_oe_n",  32'(gpio_oe_n), 32'h0000_FFFF);
        bus_req = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("arst_noack", 32'(bus_ack), 32'h0);
        rdchk("arst_dir", 3'd1, 16'h0000);
        rdchk("arst_stat", 3'd6, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
